// File: rtl/csr_burst_pkg.sv
// Shared types and constants for the CSR burst splitter.
// Holds the FSM state encoding, the fabricated-beat pattern and default widths.
package csr_burst_pkg;

  localparam int CSR_BURST_DATA_W    = 32;
  localparam int CSR_BURST_ADDR_W    = 16;
  localparam int CSR_BURST_BURST_W   = 4;
  localparam int CSR_BURST_TIMEOUT_W = 8;

  localparam logic [31:0] CSR_BURST_DEAD_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_ISSUE = 2'd2,
    ST_RD_DRAIN = 2'd3
  } csr_burst_state_t;

endpackage

// File: rtl/csr_burst_timeout.sv
// Read watchdog for the CSR burst splitter: counts idle cycles of an open read
// burst and flags expiry at the all-ones count, then restarts from zero.
module csr_burst_timeout
  import csr_burst_pkg::*;
#(
  parameter int TIMEOUT_W = CSR_BURST_TIMEOUT_W
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic active,
  input  logic clear,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt_q;

  assign expired = &cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (!active || clear || expired) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/csr_burst_splitter.sv
// Avalon-MM burst to single-beat adapter in front of the CSR converter.
// Optional read watchdog: define CSR_BURST_SPLITTER_TIMEOUT_EN.
module csr_burst_splitter
  import csr_burst_pkg::*;
#(
  parameter int DATA_W    = CSR_BURST_DATA_W,
  parameter int ADDR_W    = CSR_BURST_ADDR_W,
  parameter int BURST_W   = CSR_BURST_BURST_W,
  parameter int TIMEOUT_W = CSR_BURST_TIMEOUT_W
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [ADDR_W-1:0]   s_address,
  input  logic [BURST_W-1:0]  s_burstcount,
  input  logic [DATA_W-1:0]   s_writedata,
  input  logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_write,
  input  logic                s_read,
  input  logic                s_debugaccess,
  output logic                s_waitrequest,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_write,
  output logic                m_read,
  output logic                m_debugaccess,
  output logic [BURST_W-1:0]  m_burstcount,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic                timeout_o
);

  csr_burst_state_t    state_q, state_d;
  logic                run_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BURST_W-1:0]  left_q, left_d;
  logic [BURST_W-1:0]  cnt_q, cnt_d;
  logic [BURST_W-1:0]  issue_q, issue_d;
  logic [BURST_W-1:0]  ret_q, ret_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic                dbg_q, dbg_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                rd_active;
  logic                fwd;
  logic                fab;

  assign rd_active = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_DRAIN);

`ifdef CSR_BURST_SPLITTER_TIMEOUT_EN
  logic               expired;
  logic               to_q;
  logic [BURST_W-1:0] gen_q;

  csr_burst_timeout #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .active  (rd_active),
    .clear   (m_readdatavalid | (m_read & ~m_waitrequest)),
    .expired (expired)
  );

  // Genuine beats are matched to slots in order; a beat whose slot was already
  // fabricated (gen_q behind ret_q) is a late answer and gets dropped.
  assign fwd = rd_active & m_readdatavalid & (gen_q == ret_q) & (ret_q != cnt_q);
  assign fab = rd_active & expired & ~fwd & (ret_q != cnt_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gen_q <= '0;
      to_q  <= 1'b0;
    end else begin
      to_q <= fab;
      if (state_q == ST_IDLE) begin
        gen_q <= '0;
      end else if (rd_active && m_readdatavalid) begin
        gen_q <= gen_q + 1'b1;
      end
    end
  end

  assign timeout_o = to_q;
`else
  assign fwd = rd_active & m_readdatavalid & (ret_q != cnt_q);
  assign fab = 1'b0;
  // The watchdog width only matters when the watchdog is built.
  assign timeout_o = (TIMEOUT_W < 0);
`endif

  assign m_burstcount    = BURST_W'(1);
  assign s_readdata      = rdata_q;
  assign s_readdatavalid = rvalid_q;

  // Next-state and command decode; run_q holds everything off until the first
  // clock after reset is released.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    left_d        = left_q;
    cnt_d         = cnt_q;
    issue_d       = issue_q;
    ret_d         = ret_q + BURST_W'(fwd | fab);
    be_d          = be_q;
    dbg_d         = dbg_q;
    s_waitrequest = 1'b1;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_address     = '0;
    m_writedata   = s_writedata;
    m_byteenable  = be_q;
    m_debugaccess = dbg_q;

    if (run_q) begin
      case (state_q)
        ST_IDLE: begin
          if (s_write) begin
            m_write       = 1'b1;
            m_address     = s_address;
            m_byteenable  = s_byteenable;
            m_debugaccess = s_debugaccess;
            s_waitrequest = m_waitrequest;
            if (!m_waitrequest && (s_burstcount > BURST_W'(1))) begin
              addr_d  = s_address + ADDR_W'(1);
              left_d  = s_burstcount - BURST_W'(1);
              state_d = ST_WR_BURST;
            end
          end else if (s_read) begin
            s_waitrequest = 1'b0;
            addr_d        = s_address;
            cnt_d         = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;
            be_d          = s_byteenable;
            dbg_d         = s_debugaccess;
            issue_d       = '0;
            ret_d         = '0;
            state_d       = ST_RD_ISSUE;
          end else begin
            s_waitrequest = 1'b0;
          end
        end
        ST_WR_BURST: begin
          if (s_write) begin
            m_write       = 1'b1;
            m_address     = addr_q;
            m_byteenable  = s_byteenable;
            m_debugaccess = s_debugaccess;
            s_waitrequest = m_waitrequest;
            if (!m_waitrequest) begin
              addr_d = addr_q + ADDR_W'(1);
              left_d = left_q - BURST_W'(1);
              if (left_q == BURST_W'(1)) begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        ST_RD_ISSUE: begin
          m_read    = 1'b1;
          m_address = addr_q + ADDR_W'(issue_q);
          if (!m_waitrequest) begin
            issue_d = issue_q + BURST_W'(1);
            if (issue_d == cnt_q) begin
              state_d = (ret_d == cnt_q) ? ST_IDLE : ST_RD_DRAIN;
            end
          end
        end
        ST_RD_DRAIN: begin
          if (ret_d == cnt_q) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      run_q    <= 1'b0;
      addr_q   <= '0;
      left_q   <= '0;
      cnt_q    <= '0;
      issue_q  <= '0;
      ret_q    <= '0;
      be_q     <= '0;
      dbg_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      addr_q   <= addr_d;
      left_q   <= left_d;
      cnt_q    <= cnt_d;
      issue_q  <= issue_d;
      ret_q    <= ret_d;
      be_q     <= be_d;
      dbg_q    <= dbg_d;
      rvalid_q <= fwd | fab;
      if (fwd) begin
        rdata_q <= m_readdata;
      end else if (fab) begin
        rdata_q <= DATA_W'(CSR_BURST_DEAD_DATA);
      end
    end
  end

  a_no_rw_collision: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(run_q && (state_q == ST_IDLE) && s_write && s_read));

endmodule

// File: tb/tb_csr_burst_splitter.sv
// Table-driven scoreboard bench for csr_burst_splitter with a latency-3
// converter model; the watchdog case runs when CSR_BURST_SPLITTER_TIMEOUT_EN is set.
module tb_csr_burst_splitter;
  import csr_burst_pkg::*;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 16;
  localparam int BURST_W = 4;
  localparam int LAT     = 3;
`ifdef CSR_BURST_SPLITTER_TIMEOUT_EN
  localparam int TIMEOUT_W = 4;
`else
  localparam int TIMEOUT_W = 8;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [ADDR_W-1:0]   s_address;
  logic [BURST_W-1:0]  s_burstcount;
  logic [DATA_W-1:0]   s_writedata;
  logic [DATA_W/8-1:0] s_byteenable;
  logic                s_write, s_read, s_debugaccess;
  logic                s_waitrequest;
  logic [DATA_W-1:0]   s_readdata;
  logic                s_readdatavalid;
  logic [ADDR_W-1:0]   m_address;
  logic [DATA_W-1:0]   m_writedata;
  logic [DATA_W/8-1:0] m_byteenable;
  logic                m_write, m_read, m_debugaccess;
  logic [BURST_W-1:0]  m_burstcount;
  logic                m_waitrequest;
  logic [DATA_W-1:0]   m_readdata;
  logic                m_readdatavalid;
  logic                timeout_o;

  always #5 clk = ~clk;

  csr_burst_splitter #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BURST_W   (BURST_W),
    .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .s_address       (s_address),
    .s_burstcount    (s_burstcount),
    .s_writedata     (s_writedata),
    .s_byteenable    (s_byteenable),
    .s_write         (s_write),
    .s_read          (s_read),
    .s_debugaccess   (s_debugaccess),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .m_address       (m_address),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_write         (m_write),
    .m_read          (m_read),
    .m_debugaccess   (m_debugaccess),
    .m_burstcount    (m_burstcount),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .timeout_o       (timeout_o)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              to;
  } beat_t;

  typedef struct {
    bit                 wr;
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] bc;
    int                 stall_beat;
    int                 stall_cyc;
    int                 exp_beats;
    logic [ADDR_W-1:0]  exp_last;
  } vec_t;

  beat_t exp_wr[$];
  beat_t exp_ra[$];
  beat_t exp_rd[$];
  vec_t  vecs[8];

  int n_cmp = 0;
  int n_bad = 0;

  // Staged command, applied at the next falling edge
  logic               c_rst_n, c_write, c_read;
  logic [ADDR_W-1:0]  c_addr;
  logic [BURST_W-1:0] c_bc;
  logic [DATA_W-1:0]  c_wdata;
  int                 stall_cnt;
  bit                 mute, inject_rdv, chk_lat, wr_phase;

  logic              pv[LAT];
  logic [DATA_W-1:0] pd[LAT];
  logic              acc_prev, prev_mrdv;
  logic [DATA_W-1:0] dat_prev;

  int                n_wbeats, n_rbeats, n_rvalid;
  logic [ADDR_W-1:0] last_addr;

  function automatic logic [DATA_W-1:0] mem_word(logic [ADDR_W-1:0] a);
    return {~a, a};
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, model the converter, then sample.
  task automatic tick();
    beat_t e;
    @(negedge clk);
    rst_n        = c_rst_n;
    s_write      = c_write;
    s_read       = c_read;
    s_address    = c_addr;
    s_burstcount = c_bc;
    s_writedata  = c_wdata;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = acc_prev && !mute;
    pd[0] = dat_prev;
    m_readdatavalid = pv[LAT-1] | inject_rdv;
    m_readdata      = inject_rdv ? 32'h0BAD_0BAD : pd[LAT-1];
    m_waitrequest   = (stall_cnt > 0);
    if (stall_cnt > 0) stall_cnt--;
    #1;
    if (m_write && !m_waitrequest) begin
      n_wbeats++;
      last_addr = m_address;
      if (exp_wr.size() == 0) checkOutput("unexpected m_write", 32'd1, 32'd0);
      else begin
        e = exp_wr.pop_front();
        checkOutput("m_address write", 32'(m_address), 32'(e.addr));
        checkOutput("m_writedata", m_writedata, e.data);
      end
    end
    if (wr_phase) checkOutput("s_waitrequest mirror", 32'(s_waitrequest), 32'(m_waitrequest));
    acc_prev = 1'b0;
    if (m_read && !m_waitrequest) begin
      n_rbeats++;
      last_addr = m_address;
      acc_prev  = 1'b1;
      dat_prev  = mem_word(m_address);
      if (exp_ra.size() == 0) checkOutput("unexpected m_read", 32'd1, 32'd0);
      else begin
        e = exp_ra.pop_front();
        checkOutput("m_address read", 32'(m_address), 32'(e.addr));
      end
    end
    if (s_readdatavalid) begin
      n_rvalid++;
      if (exp_rd.size() == 0) checkOutput("unexpected s_readdatavalid", 32'd1, 32'd0);
      else begin
        e = exp_rd.pop_front();
        checkOutput("s_readdata", s_readdata, e.data);
        checkOutput("timeout_o with beat", 32'(timeout_o), 32'(e.to));
      end
    end else if (timeout_o) begin
      checkOutput("timeout_o without beat", 32'(timeout_o), 32'd0);
    end
    if (chk_lat) checkOutput("readdatavalid latency", 32'(s_readdatavalid), 32'(prev_mrdv));
    prev_mrdv = m_readdatavalid;
  endtask

  task automatic checkResetState(string tag);
    checkOutput({tag, " s_waitrequest"}, 32'(s_waitrequest), 32'd1);
    checkOutput({tag, " s_readdatavalid"}, 32'(s_readdatavalid), 32'd0);
    checkOutput({tag, " s_readdata"}, s_readdata, 32'd0);
    checkOutput({tag, " m_read"}, 32'(m_read), 32'd0);
    checkOutput({tag, " m_write"}, 32'(m_write), 32'd0);
    checkOutput({tag, " m_address"}, 32'(m_address), 32'd0);
    checkOutput({tag, " m_burstcount"}, 32'(m_burstcount), 32'd1);
    checkOutput({tag, " timeout_o"}, 32'(timeout_o), 32'd0);
  endtask

  task automatic pushRead(logic [ADDR_W-1:0] base, int n);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = base + ADDR_W'(i);
      e.data = mem_word(e.addr);
      e.to   = 1'b0;
      exp_ra.push_back(e);
      exp_rd.push_back(e);
    end
  endtask

  task automatic waitAccept(string name);
    int budget = 50;
    do begin
      tick();
      budget--;
    end while (s_waitrequest && budget > 0);
    if (s_waitrequest) checkOutput({name, " accept budget"}, 32'd1, 32'd0);
  endtask

  task automatic waitReadDone(string name, int limit);
    int budget = limit;
    while ((exp_ra.size() != 0 || exp_rd.size() != 0) && budget > 0) begin
      tick();
      budget--;
    end
    if (exp_ra.size() != 0 || exp_rd.size() != 0)
      checkOutput({name, " read budget"}, 32'd1, 32'd0);
  endtask

  task automatic applyStimulus(vec_t v);
    beat_t e;
    int    n;
    n = (v.bc == '0) ? 1 : int'(v.bc);
    n_wbeats = 0;
    n_rbeats = 0;
    if (v.wr) begin
      wr_phase = 1'b1;
      for (int i = 0; i < n; i++) begin
        c_write = 1'b1;
        c_bc    = v.bc;
        c_addr  = (i == 0) ? v.addr : (v.addr ^ 16'h5A5A);
        c_wdata = $urandom;
        e.addr  = v.addr + ADDR_W'(i);
        e.data  = c_wdata;
        e.to    = 1'b0;
        exp_wr.push_back(e);
        if (i == v.stall_beat) stall_cnt = v.stall_cyc;
        waitAccept("write");
      end
      c_write  = 1'b0;
      wr_phase = 1'b0;
      checkOutput("write beat count", 32'(n_wbeats), 32'(v.exp_beats));
    end else begin
      chk_lat = 1'b1;
      pushRead(v.addr, n);
      c_read = 1'b1;
      c_addr = v.addr;
      c_bc   = v.bc;
      waitAccept("read");
      c_read = 1'b0;
      waitReadDone("read", 300);
      chk_lat = 1'b0;
      checkOutput("read beat count", 32'(n_rbeats), 32'(v.exp_beats));
    end
    checkOutput("last m_address", 32'(last_addr), 32'(v.exp_last));
    tick();
    checkOutput("idle s_waitrequest", 32'(s_waitrequest), 32'd0);
  endtask

  initial begin
    beat_t e;
    int    budget;

    vecs[0] = '{1'b1, 16'h0010, 4'd4,  1, 2, 4,  16'h0013};
    vecs[1] = '{1'b0, 16'h0100, 4'd8,  -1, 0, 8,  16'h0107};
    vecs[2] = '{1'b0, 16'hFFFF, 4'd2,  -1, 0, 2,  16'h0000};
    vecs[3] = '{1'b1, 16'h0040, 4'd0,  -1, 0, 1,  16'h0040};
    vecs[4] = '{1'b1, 16'hFFFE, 4'd3,  2, 1, 3,  16'h0000};
    vecs[5] = '{1'b0, 16'h0200, 4'd1,  -1, 0, 1,  16'h0200};
    vecs[6] = '{1'b0, 16'h0300, 4'd15, -1, 0, 15, 16'h030E};
    vecs[7] = '{1'b1, 16'h0500, 4'd15, 7, 3, 15, 16'h050E};

    rst_n = 1'b0; c_rst_n = 1'b0;
    c_write = 1'b0; c_read = 1'b0; c_addr = '0; c_bc = '0; c_wdata = '0;
    s_byteenable = '1; s_debugaccess = 1'b0;
    stall_cnt = 0; mute = 1'b0; inject_rdv = 1'b0; chk_lat = 1'b0; wr_phase = 1'b0;
    acc_prev = 1'b0; prev_mrdv = 1'b0; dat_prev = '0;
    n_wbeats = 0; n_rbeats = 0; n_rvalid = 0; last_addr = '0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end

    tick();
    tick();
    checkResetState("reset");
    c_rst_n = 1'b1;
    tick();
    tick();
    checkOutput("waitrequest released", 32'(s_waitrequest), 32'd0);

    inject_rdv = 1'b1;
    tick();
    inject_rdv = 1'b0;
    tick();
    checkOutput("stray readdatavalid dropped", 32'(s_readdatavalid), 32'd0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("[TB] reset during 8-beat read");
    pushRead(16'h0400, 8);
    c_read = 1'b1; c_addr = 16'h0400; c_bc = 4'd8;
    waitAccept("pre-reset read");
    c_read   = 1'b0;
    n_rvalid = 0;
    budget   = 60;
    while (n_rvalid < 3 && budget > 0) begin
      tick();
      budget--;
    end
    if (n_rvalid < 3) checkOutput("pre-reset beats budget", 32'd1, 32'd0);
    exp_ra.delete();
    exp_rd.delete();
    c_rst_n = 1'b0;
    tick();
    checkResetState("mid-burst reset");
    tick();
    c_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("no old beats after reset", 32'(n_rvalid), 32'd3);
    applyStimulus('{1'b0, 16'h0600, 4'd1, -1, 0, 1, 16'h0600});

`ifdef CSR_BURST_SPLITTER_TIMEOUT_EN
    $display("[TB] watchdog on unanswered read");
    mute   = 1'b1;
    e.addr = 16'h0700;
    e.data = 32'hDEADBEEF;
    e.to   = 1'b1;
    exp_ra.push_back(e);
    exp_rd.push_back(e);
    c_read = 1'b1; c_addr = 16'h0700; c_bc = 4'd1;
    waitAccept("watchdog read");
    c_read = 1'b0;
    waitReadDone("watchdog", 40);
    tick();
    checkOutput("timeout_o single pulse", 32'(timeout_o), 32'd0);
    checkOutput("idle after watchdog", 32'(s_waitrequest), 32'd0);
    mute = 1'b0;
`endif

    checkOutput("write queue drained", 32'(exp_wr.size()), 32'd0);
    checkOutput("read addr queue drained", 32'(exp_ra.size()), 32'd0);
    checkOutput("read data queue drained", 32'(exp_rd.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
